// File: rtl/saber_pkg.sv
// Shared definitions for the PolMem streaming path.
// Holds the PolMem geometry, the Saber polynomial shape (words per
// polynomial and polynomials per vector) and the reader FSM state encoding.
package saber_pkg;

    localparam int POLMEM_ADDR_W = 8;
    localparam int POLMEM_DATA_W = 64;
    localparam int SABER_N_WORDS = 64;
    localparam int SABER_L       = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry in-order FIFO used as the skid buffer between PolMem and the
// operand FIFO.  Entries are kept in a shift arrangement: entry 0 is always
// the head, so the head is a plain register and can drive outputs directly.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   wr        write wdata this cycle (caller guarantees no overflow)
//   wdata     entry to store
//   rd        remove the head this cycle (only when count != 0)
//   head      current head entry
//   count     number of valid entries, 0..2
module skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] entry1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head   <= '0;
            entry1 <= '0;
            count  <= '0;
        end else begin
            case ({wr, rd})
                2'b10: begin
                    if (count == 2'd0) head <= wdata;
                    else               entry1 <= wdata;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= entry1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Head leaves and the new word enters; occupancy unchanged.
                    if (count == 2'd1) begin
                        head <= wdata;
                    end else begin
                        head   <= entry1;
                        entry1 <= wdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/polmem_stream_reader.sv
// Streams NUM_POLY consecutive NUM_WORDS-word polynomials from PolMem
// (1-cycle-latency BRAM) into the operand FIFO of the polynomial multiplier.
// A 2-entry skid buffer absorbs FIFO back-pressure so no BRAM word is lost
// or duplicated.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           1-cycle start pulse, honoured only in IDLE
//   src_base        first PolMem address, captured on accepted start
//   PolMem_address  BRAM read address (wraps modulo 2**ADDR_W)
//   PolMem_ren      BRAM read enable, data returns next cycle
//   PolMem_dout     BRAM read data
//   fifo_din        word pushed to the operand FIFO (skid head)
//   fifo_wen        FIFO push
//   fifo_full       FIFO cannot accept a push this cycle
//   fifo_last       pushed word is the last word of its polynomial
//   poly_idx        polynomial index of the word on fifo_din
//   busy            high from accepted start until done
//   done            1-cycle pulse after the final push
module polmem_stream_reader
    import saber_pkg::*;
#(
    parameter int ADDR_W    = POLMEM_ADDR_W,
    parameter int DATA_W    = POLMEM_DATA_W,
    parameter int NUM_WORDS = SABER_N_WORDS,
    parameter int NUM_POLY  = SABER_L
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    output logic [ADDR_W-1:0] PolMem_address,
    output logic              PolMem_ren,
    input  logic [DATA_W-1:0] PolMem_dout,
    output logic [DATA_W-1:0] fifo_din,
    output logic              fifo_wen,
    input  logic              fifo_full,
    output logic              fifo_last,
    output logic [1:0]        poly_idx,
    output logic              busy,
    output logic              done
);

    localparam int TOTAL = NUM_POLY * NUM_WORDS;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int WRD_W = $clog2(NUM_WORDS);
    localparam int ENT_W = DATA_W + 3;
    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);

    state_t            state;
    logic [CNT_W-1:0]  rd_cnt;
    logic              vld_p1;
    logic [2:0]        tag_p1;
    logic [2:0]        issue_tag;
    logic [1:0]        buf_cnt;
    logic [ENT_W-1:0]  head;
    logic              pop;
    logic              reads_left;
    logic [2:0]        occ_next;

    assign pop        = (buf_cnt != 2'd0) && !fifo_full;
    assign fifo_wen   = pop;
    assign reads_left = (rd_cnt != TOTAL_C);

    // Buffer occupancy after this edge, counting the word returning now.
    // Using the current pop here lets a read be issued in the same cycle
    // a slot frees, which keeps 1 word/cycle through a 2-entry buffer.
    assign occ_next = {1'b0, buf_cnt} + {2'b00, vld_p1} - {2'b00, pop};

    assign PolMem_ren = (state == ST_READ) && reads_left && (occ_next < 3'd2);

    // Tag travels with the read: {polynomial index, last word of polynomial}.
    assign issue_tag = {2'(rd_cnt >> WRD_W), &rd_cnt[WRD_W-1:0]};

    // Stage p0 -> p1: read issued, BRAM access in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            rd_cnt         <= '0;
            PolMem_address <= '0;
            vld_p1         <= 1'b0;
            tag_p1         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            vld_p1 <= PolMem_ren;
            if (PolMem_ren) tag_p1 <= issue_tag;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state          <= ST_READ;
                        PolMem_address <= src_base;
                        rd_cnt         <= '0;
                        busy           <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (PolMem_ren) begin
                        PolMem_address <= PolMem_address + ADDR_W'(1);
                        rd_cnt         <= rd_cnt + CNT_W'(1);
                        if (rd_cnt == LAST_C) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Leave on the cycle of the final pop so done follows it directly.
                    if (occ_next == 3'd0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage p1 -> p2: returning BRAM word captured into the skid buffer
    skid_fifo2 #(
        .W(ENT_W)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .wr    (vld_p1),
        .wdata ({tag_p1, PolMem_dout}),
        .rd    (pop),
        .head  (head),
        .count (buf_cnt)
    );

    assign {poly_idx, fifo_last, fifo_din} = head;

endmodule
